// File: rtl/sata_command_sequencer_if.sv
// rtl/sata_command_sequencer_if.sv - command/status bundle between the sequencer and the SATA stack
interface sata_command_sequencer_if;
   logic        linkup;
   logic        sata_ready;
   logic        sata_busy;
   logic        d2h_reg_stb;
   logic [7:0]  d2h_status;
   logic [7:0]  d2h_error;
   logic [7:0]  hard_drive_command;
   logic        execute_command_stb;
   logic [15:0] sector_count;
   logic [47:0] sector_address;

   modport master (
      input  linkup, sata_ready, sata_busy, d2h_reg_stb, d2h_status, d2h_error,
      output hard_drive_command, execute_command_stb, sector_count, sector_address
   );

   modport slave (
      output linkup, sata_ready, sata_busy, d2h_reg_stb, d2h_status, d2h_error,
      input  hard_drive_command, execute_command_stb, sector_count, sector_address
   );
endinterface

// File: rtl/sata_command_sequencer.sv
// rtl/sata_command_sequencer.sv - splits a sector job into DMA EXT commands and tracks completion
// Optional single per-chunk retry on device error or timeout: define SATA_CMD_SEQ_RETRY_EN.
module sata_command_sequencer #(
   parameter int CHUNK_SECTORS  = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_stb,
   input  logic        req_write,
   input  logic [47:0] req_lba,
   input  logic [31:0] req_sectors,
   output logic        busy,
   output logic        done_stb,
   output logic [1:0]  error_code,
   output logic [15:0] error_status,
   output logic [31:0] sectors_done,
   sata_command_sequencer_if.master sata
);

   localparam logic [31:0] CHUNK_W  = 32'(CHUNK_SECTORS);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  CMD_WRITE_DMA_EXT = 8'h35;
   localparam logic [7:0]  CMD_READ_DMA_EXT  = 8'h25;

   typedef enum logic [2:0] {
      IDLE, WAIT_READY, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, FINISH
   } state_t;

   state_t      state, state_n;

   logic        job_write;
   logic [31:0] remaining;
   logic [47:0] next_lba;
   logic [31:0] chunk;
   logic [31:0] chunk_n;
   logic [31:0] tcnt;
   logic [7:0]  cap_status;
   logic [7:0]  cap_error;
   logic [7:0]  cmd_reg;
   logic        exec_reg;
   logic [15:0] count_reg;
   logic [47:0] addr_reg;

   logic        accept;
   logic        load_cmd;
   logic        advance;
   logic        cap_d2h;
   logic        fail;
   logic [1:0]  fail_code;
   logic        end_err;
   logic [1:0]  end_code;
   logic        link_active;
   logic        tmo_hit;
   logic        dev_err;
`ifdef SATA_CMD_SEQ_RETRY_EN
   logic        retry_used;
   logic        retry_take;
`endif

   assign chunk_n     = (remaining < CHUNK_W) ? remaining : CHUNK_W;
   assign link_active = (state != IDLE) && (state != FINISH);
   assign tmo_hit     = (tcnt == TMO_LAST);
   assign dev_err     = cap_status[0] | cap_status[5];

   assign busy     = link_active;
   assign done_stb = (state == FINISH);

   assign sata.hard_drive_command  = cmd_reg;
   assign sata.execute_command_stb = exec_reg;
   assign sata.sector_count        = count_reg;
   assign sata.sector_address      = addr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      load_cmd  = 1'b0;
      advance   = 1'b0;
      cap_d2h   = 1'b0;
      fail      = 1'b0;
      fail_code = 2'd0;
      end_err   = 1'b0;
      end_code  = 2'd0;
`ifdef SATA_CMD_SEQ_RETRY_EN
      retry_take = 1'b0;
`endif
      // Link loss outranks every other event, including a D2H FIS in the same cycle.
      if (link_active && !sata.linkup) begin
         end_err  = 1'b1;
         end_code = 2'd3;
         state_n  = FINISH;
      end else begin
         case (state)
            IDLE: begin
               if (req_stb) begin
                  accept  = 1'b1;
                  state_n = (req_sectors == 32'd0) ? FINISH : WAIT_READY;
               end
            end
            WAIT_READY: begin
               if (sata.sata_ready) begin
                  load_cmd = 1'b1;
                  state_n  = ISSUE;
               end
            end
            ISSUE: begin
               state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (sata.sata_busy) begin
                  state_n = WAIT_DONE;
               end else if (tmo_hit) begin
                  fail      = 1'b1;
                  fail_code = 2'd2;
               end
            end
            WAIT_DONE: begin
               if (sata.d2h_reg_stb) begin
                  cap_d2h = 1'b1;
                  state_n = CHECK;
               end else if (tmo_hit) begin
                  fail      = 1'b1;
                  fail_code = 2'd2;
               end
            end
            CHECK: begin
               if (dev_err) begin
                  fail      = 1'b1;
                  fail_code = 2'd1;
               end else begin
                  advance = 1'b1;
                  state_n = (remaining == chunk) ? FINISH : WAIT_READY;
               end
            end
            FINISH: begin
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase

         if (fail) begin
`ifdef SATA_CMD_SEQ_RETRY_EN
            if (!retry_used) begin
               retry_take = 1'b1;
               state_n    = WAIT_READY;
            end else begin
               end_err  = 1'b1;
               end_code = fail_code;
               state_n  = FINISH;
            end
`else
            end_err  = 1'b1;
            end_code = fail_code;
            state_n  = FINISH;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         job_write    <= 1'b0;
         remaining    <= 32'd0;
         next_lba     <= 48'd0;
         chunk        <= 32'd0;
         tcnt         <= 32'd0;
         cap_status   <= 8'd0;
         cap_error    <= 8'd0;
         cmd_reg      <= 8'd0;
         exec_reg     <= 1'b0;
         count_reg    <= 16'd0;
         addr_reg     <= 48'd0;
         error_code   <= 2'd0;
         error_status <= 16'd0;
         sectors_done <= 32'd0;
      end else begin
         if (accept) begin
            job_write    <= req_write;
            remaining    <= req_sectors;
            next_lba     <= req_lba;
            sectors_done <= 32'd0;
            error_code   <= 2'd0;
         end
         // Command fields are registered on the way into ISSUE and then left alone.
         if (load_cmd) begin
            chunk     <= chunk_n;
            cmd_reg   <= job_write ? CMD_WRITE_DMA_EXT : CMD_READ_DMA_EXT;
            count_reg <= chunk_n[15:0];
            addr_reg  <= next_lba;
         end
         exec_reg <= load_cmd;
         if (state == ISSUE) begin
            tcnt <= 32'd0;
         end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            tcnt <= tcnt + 32'd1;
         end
         if (cap_d2h) begin
            cap_status <= sata.d2h_status;
            cap_error  <= sata.d2h_error;
         end
         if (advance) begin
            sectors_done <= sectors_done + chunk;
            next_lba     <= next_lba + {16'd0, chunk};
            remaining    <= remaining - chunk;
         end
         if (end_err) begin
            error_code <= end_code;
            if (end_code == 2'd1) begin
               error_status <= {cap_error, cap_status};
            end
         end
      end
   end

`ifdef SATA_CMD_SEQ_RETRY_EN
   // One retry allowance per chunk: restored on a new job or a completed chunk.
   always_ff @(posedge clk) begin
      if (rst) begin
         retry_used <= 1'b0;
      end else if (accept || advance) begin
         retry_used <= 1'b0;
      end else if (retry_take) begin
         retry_used <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sata_command_sequencer.sv
// tb/tb_sata_command_sequencer.sv - table, directed and random checks against a faux SATA drive
module tb_sata_command_sequencer;
   localparam int CH  = 256;
   localparam int TMO = 100;
`ifdef SATA_CMD_SEQ_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        req_stb;
   logic        req_write;
   logic [47:0] req_lba;
   logic [31:0] req_sectors;
   logic        busy;
   logic        done_stb;
   logic [1:0]  error_code;
   logic [15:0] error_status;
   logic [31:0] sectors_done;

   sata_command_sequencer_if sif ();

   sata_command_sequencer #(.CHUNK_SECTORS(CH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .req_stb(req_stb), .req_write(req_write),
      .req_lba(req_lba), .req_sectors(req_sectors), .busy(busy), .done_stb(done_stb),
      .error_code(error_code), .error_status(error_status), .sectors_done(sectors_done),
      .sata(sif)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int req_cyc, done_cyc, busy_cyc;

   int fail_lo = -1, fail_hi = -1, drop_idx = -1, busy_dly = 1, done_dly = 3;
   bit silent = 0, ready_rand = 0;
   logic [7:0] fst = 8'h51, fer = 8'h04, good_st = 8'h50;
   bit drv_pending = 0;
   int drv_cnt = 0, drv_idx = 0;

   logic [7:0]  q_cmd[$];
   logic [15:0] q_cnt[$];
   logic [47:0] q_lba[$];
   int          q_cyc[$];

   logic [7:0]  m_cmd[$];
   logic [15:0] m_cnt[$];
   logic [47:0] m_lba[$];
   logic [31:0] m_done;
   logic [1:0]  m_code;
   logic [15:0] m_estat;

   typedef struct {
      bit          wr;
      logic [47:0] lba;
      logic [31:0] secs;
      int          flo;
      int          fhi;
      logic [7:0]  fst;
      logic [7:0]  fer;
      int          exp_n;
      logic [31:0] exp_done;
      logic [1:0]  exp_code;
      logic [15:0] exp_estat;
   } vec_t;
   vec_t vecs[8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (done_stb) done_cnt++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Faux drive: logs each command, raises sata_busy, then answers with a D2H FIS.
   initial forever begin
      @(negedge clk);
      sif.d2h_reg_stb = 1'b0;
      if (ready_rand) sif.sata_ready = ($urandom_range(0, 3) != 0);
      if (sif.execute_command_stb) begin
         q_cmd.push_back(sif.hard_drive_command);
         q_cnt.push_back(sif.sector_count);
         q_lba.push_back(sif.sector_address);
         q_cyc.push_back(cyc);
         drv_idx = q_cmd.size() - 1;
         drv_pending = 1'b1;
         drv_cnt = 0;
         sif.sata_busy = 1'b0;
      end else if (drv_pending) begin
         drv_cnt++;
         if (drv_cnt == busy_dly) begin
            sif.sata_busy = 1'b1;
            busy_cyc = cyc;
         end
         if (drv_idx == drop_idx && drv_cnt == busy_dly + 1) sif.linkup = 1'b0;
         if (!silent && drv_cnt == done_dly) begin
            sif.d2h_reg_stb = 1'b1;
            sif.sata_busy = 1'b0;
            drv_pending = 1'b0;
            if (drv_idx >= fail_lo && drv_idx <= fail_hi) begin
               sif.d2h_status = fst;
               sif.d2h_error  = fer;
            end else begin
               sif.d2h_status = good_st;
               sif.d2h_error  = 8'($urandom);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the job chunk by chunk straight from the job rules.
   task automatic model(input bit wr, input logic [47:0] lba, input logic [31:0] secs);
      logic [31:0] rem = secs;
      logic [47:0] a = lba;
      logic [31:0] n;
      int idx = 0;
      bit spare = RETRY;
      m_cmd.delete(); m_cnt.delete(); m_lba.delete();
      m_done = 0; m_code = 0; m_estat = 0;
      while (rem != 0) begin
         n = (rem < CH) ? rem : CH;
         m_cmd.push_back(wr ? 8'h35 : 8'h25);
         m_cnt.push_back(n[15:0]);
         m_lba.push_back(a);
         if (idx == drop_idx) begin
            m_code = 3;
            break;
         end
         if (silent || (idx >= fail_lo && idx <= fail_hi)) begin
            idx++;
            if (spare) begin
               spare = 0;
               continue;
            end
            m_code = silent ? 2'd2 : 2'd1;
            m_estat = {fer, fst};
            break;
         end
         idx++;
         spare = RETRY;
         m_done += n;
         a += 48'(n);
         rem -= n;
      end
   endtask

   task automatic prep();
      for (int i = 0; i < 100 && drv_pending; i++) @(negedge clk);
      drv_pending = 1'b0;
      sif.sata_busy = 1'b0;
      q_cmd.delete(); q_cnt.delete(); q_lba.delete(); q_cyc.delete();
      @(negedge clk);
   endtask

   task automatic run_job(input bit wr, input logic [47:0] lba, input logic [31:0] secs,
                          input bit inject, input bit chk_lat);
      bit got;
      int nmin;
      prep();
      model(wr, lba, secs);
      req_write = wr; req_lba = lba; req_sectors = secs; req_stb = 1'b1;
      req_cyc = cyc;
      @(negedge clk);
      req_stb = 1'b0;
      if (secs == 0) chk("zero_done_next", done_stb, 1);
      else chk("busy_next", busy, 1);
      got = done_stb;
      for (int k = 0; k < 20000 && !got; k++) begin
         @(negedge clk);
         if (inject && k == 3) begin
            req_stb = 1'b1; req_write = ~wr; req_lba = 48'hABC; req_sectors = 5;
         end else if (inject && k == 4) begin
            req_stb = 1'b0;
         end
         got = done_stb;
      end
      req_stb = 1'b0;
      done_cyc = cyc;
      chk("done_seen", got, 1);
      chk("busy_at_done", busy, 0);
      chk("issue_count", q_cmd.size(), m_cmd.size());
      nmin = (q_cmd.size() < m_cmd.size()) ? q_cmd.size() : m_cmd.size();
      for (int i = 0; i < nmin; i++) begin
         chk($sformatf("issue%0d_cmd", i), q_cmd[i], m_cmd[i]);
         chk($sformatf("issue%0d_cnt", i), q_cnt[i], m_cnt[i]);
         chk($sformatf("issue%0d_lba", i), q_lba[i], m_lba[i]);
      end
      chk("sectors_done", sectors_done, m_done);
      chk("error_code", error_code, m_code);
      if (m_code == 1) chk("error_status", error_status, m_estat);
      if (chk_lat && q_cyc.size() > 0) chk("stb_latency", q_cyc[0] - req_cyc, 2);
      @(negedge clk);
      chk("done_one_cycle", done_stb, 0);
      chk("code_held", error_code, m_code);
   endtask

   initial begin
      int d0;
      rst = 1'b1; req_stb = 1'b0; req_write = 1'b0; req_lba = 0; req_sectors = 0;
      sif.linkup = 1'b1; sif.sata_ready = 1'b1; sif.sata_busy = 1'b0;
      sif.d2h_reg_stb = 1'b0; sif.d2h_status = 8'h00; sif.d2h_error = 8'h00;

      vecs[0] = '{1'b1, 48'h1000, 600, -1, -1, 8'h00, 8'h00, 3, 600, 2'd0, 16'h0};
      vecs[1] = '{1'b0, 48'h2000, 10, 0, 99, 8'h51, 8'h04, RETRY ? 2 : 1, 0, 2'd1, 16'h0451};
      vecs[2] = '{1'b0, 48'h20, 256, -1, -1, 8'h00, 8'h00, 1, 256, 2'd0, 16'h0};
      vecs[3] = '{1'b1, 48'h3000, 257, -1, -1, 8'h00, 8'h00, 2, 257, 2'd0, 16'h0};
      vecs[4] = '{1'b1, 48'h0, 1, -1, -1, 8'h00, 8'h00, 1, 1, 2'd0, 16'h0};
      vecs[5] = '{1'b0, 48'h4000, 512, 1, 1, 8'h70, 8'h10, RETRY ? 3 : 2, RETRY ? 512 : 256,
                  RETRY ? 2'd0 : 2'd1, 16'h1070};
      vecs[6] = '{1'b1, 48'hFFFF_FFFF_FFF0, 300, -1, -1, 8'h00, 8'h00, 2, 300, 2'd0, 16'h0};
      vecs[7] = '{1'b0, 48'h5000, 65, 0, 0, 8'h21, 8'h80, RETRY ? 2 : 1, RETRY ? 65 : 0,
                  RETRY ? 2'd0 : 2'd1, 16'h8021};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_stb, 0);
      chk("rst_exec", sif.execute_command_stb, 0);
      chk("rst_code", error_code, 0);
      chk("rst_estat", error_status, 0);
      chk("rst_sdone", sectors_done, 0);
      chk("rst_cmd", sif.hard_drive_command, 0);
      chk("rst_count", sif.sector_count, 0);
      chk("rst_addr", sif.sector_address, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         fail_lo = vecs[i].flo; fail_hi = vecs[i].fhi;
         fst = vecs[i].fst; fer = vecs[i].fer; good_st = 8'h50;
         busy_dly = 1 + i % 3; done_dly = busy_dly + 1 + i % 2;
         run_job(vecs[i].wr, vecs[i].lba, vecs[i].secs, 0, 1);
         chk($sformatf("v%0d_issues", i), q_cmd.size(), vecs[i].exp_n);
         chk($sformatf("v%0d_sdone", i), sectors_done, vecs[i].exp_done);
         chk($sformatf("v%0d_code", i), error_code, vecs[i].exp_code);
         if (vecs[i].exp_code == 1) chk($sformatf("v%0d_estat", i), error_status, vecs[i].exp_estat);
      end

      fail_lo = -1; fail_hi = -1; busy_dly = 1; done_dly = 3;
      run_job(1, 48'h1000, 600, 0, 1);
      chk("w600_cmd0", (q_cmd.size() > 0) ? q_cmd[0] : 8'h00, 8'h35);
      chk("w600_cnt2", (q_cnt.size() > 2) ? q_cnt[2] : 16'hFFFF, 88);
      chk("w600_lba1", (q_lba.size() > 1) ? q_lba[1] : 48'h0, 48'h1100);
      chk("w600_lba2", (q_lba.size() > 2) ? q_lba[2] : 48'h0, 48'h1200);

      silent = 1'b1; busy_dly = 1;
      run_job(0, 48'h6000, 10, 0, 1);
      chk("timeout_code", error_code, 2);
      chk("timeout_cycles", done_cyc - busy_cyc, TMO);
      silent = 1'b0; drv_pending = 1'b0; sif.sata_busy = 1'b0;

      drop_idx = 1; busy_dly = 1; done_dly = 6;
      run_job(1, 48'h7000, 600, 0, 1);
      chk("link_code", error_code, 3);
      chk("link_sdone", sectors_done, CH);
      drop_idx = -1; sif.linkup = 1'b1; done_dly = 3;

      run_job(1, 48'h77, 0, 0, 1);
      run_job(0, 48'h8000, 600, 1, 1);

      prep();
      done_dly = 20;
      req_write = 1'b1; req_lba = 48'h9000; req_sectors = 600; req_stb = 1'b1;
      @(negedge clk);
      req_stb = 1'b0;
      for (int k = 0; k < 100 && !(q_cmd.size() > 0 && sif.sata_busy); k++) @(negedge clk);
      chk("rst_job_started", q_cmd.size(), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done_stb, 0);
      chk("mid_rst_exec", sif.execute_command_stb, 0);
      chk("mid_rst_code", error_code, 0);
      chk("mid_rst_cmd", sif.hard_drive_command, 0);
      chk("mid_rst_count", sif.sector_count, 0);
      chk("mid_rst_addr", sif.sector_address, 0);
      d0 = done_cnt;
      repeat (40) @(negedge clk);
      chk("no_done_after_rst", done_cnt - d0, 0);
      done_dly = 3;
      run_job(1, 48'h9000, 300, 0, 1);

      for (int r = 0; r < 24; r++) begin
         bit wr;
         logic [47:0] lba;
         logic [31:0] secs;
         wr = 1'($urandom);
         case ($urandom_range(0, 5))
            0: secs = $urandom_range(1, 255);
            1: secs = 256 * $urandom_range(1, 3);
            2: secs = $urandom_range(257, 900);
            3: secs = 0;
            default: secs = $urandom_range(1, 700);
         endcase
         if ($urandom_range(0, 3) == 0) lba = 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 600));
         else lba = {16'($urandom), 32'($urandom)};
         if ($urandom_range(0, 2) == 0) begin
            fail_lo = $urandom_range(0, 3);
            fail_hi = fail_lo + $urandom_range(0, 1);
         end else begin
            fail_lo = -1; fail_hi = -1;
         end
         fst = 8'($urandom) | (($urandom_range(0, 1) == 0) ? 8'h01 : 8'h20);
         fer = 8'($urandom);
         good_st = 8'($urandom) & 8'hDE;
         busy_dly = $urandom_range(1, 3);
         done_dly = busy_dly + $urandom_range(1, 4);
         ready_rand = 1'($urandom_range(0, 1));
         run_job(wr, lba, secs, 0, !ready_rand);
         ready_rand = 1'b0;
         sif.sata_ready = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sata_command_sequencer.md
SATA_COMMAND_SEQUENCER -- requirements
Module: sata_command_sequencer

Interface
REQ-001 SHALL have parameter CHUNK_SECTORS, default 256, max sectors per issued command (legal 1..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clk cycles from command strobe to D2H register FIS.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_stb  input  1  one-cycle job request.
REQ-006 SHALL have port req_write  input  1  1 = write to drive, 0 = read from drive.
REQ-007 SHALL have port req_lba  input  48  starting LBA.
REQ-008 SHALL have port req_sectors  input  32  total sectors in the job.
REQ-009 SHALL have port busy  output  1  job in progress.
REQ-010 SHALL have port done_stb  output  1  one-cycle job completion pulse, success or failure.
REQ-011 SHALL have port error_code  output  2  0 none, 1 device error, 2 timeout, 3 link lost.
REQ-012 SHALL have port error_status  output  16  {d2h_error, d2h_status} captured on device error.
REQ-013 SHALL have port sectors_done  output  32  sectors completed without error.
REQ-014 SHALL have ports linkup, sata_ready, sata_busy, d2h_reg_stb  input  1 each  status from the SATA stack.
REQ-015 SHALL have ports d2h_status, d2h_error  input  8 each  fields of the last D2H register FIS.
REQ-016 SHALL have ports hard_drive_command  output 8, execute_command_stb  output 1, sector_count  output 16, sector_address  output 48  command interface to the SATA stack.

Function
REQ-017 States: IDLE, WAIT_READY, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, FINISH.
REQ-018 IDLE: req_stb latches req_write, req_lba, req_sectors into remaining/next_lba; clears sectors_done and error_code; busy=1 the next cycle; go to WAIT_READY.
REQ-019 req_stb while busy=1 SHALL be ignored.
REQ-020 req_sectors=0: no command issued; done_stb one cycle after req_stb, error_code=0.
REQ-021 WAIT_READY: wait for linkup=1 and sata_ready=1, then go to ISSUE.
REQ-022 ISSUE, exactly one cycle:
- chunk = min(remaining, CHUNK_SECTORS)
- sector_count = chunk[15:0]; sector_address = next_lba
- hard_drive_command = 8'h35 (write DMA ext) or 8'h25 (read DMA ext)
- execute_command_stb = 1
- timeout counter cleared
- command outputs held stable until the next ISSUE.
REQ-023 WAIT_BUSY: wait for sata_busy=1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: wait for d2h_reg_stb; capture d2h_status/d2h_error; go to CHECK.
REQ-025 Timeout counter runs in WAIT_BUSY and WAIT_DONE; reaching TIMEOUT_CYCLES sets error_code=2 and goes to FINISH.
REQ-026 CHECK, device error = d2h_status bit0 (ERR) or bit5 (DF):
- device error: error_code=1, error_status captured, go to FINISH
- otherwise: sectors_done += chunk, next_lba += chunk (48-bit wrap), remaining -= chunk
- remaining=0: go to FINISH; else go to WAIT_READY.
REQ-027 linkup=0 in any non-IDLE, non-FINISH state SHALL set error_code=3 and go to FINISH; this takes priority over a d2h_reg_stb in the same cycle.
REQ-028 FINISH: done_stb=1 for one cycle, busy=0, return to IDLE; error_code and sectors_done held until the next accepted req_stb.
REQ-029 Latency: execute_command_stb SHALL assert 2 cycles after req_stb when linkup=sata_ready=1.

Reset
REQ-030 rst=1 at any clock edge SHALL force IDLE and set busy=0, done_stb=0, execute_command_stb=0, error_code=0, error_status=0, sectors_done=0, hard_drive_command=0, sector_count=0, sector_address=0; this aborts any job in progress with no done_stb.

Configuration
REQ-031 Macro SATA_CMD_SEQ_RETRY_EN.
- Defined: the first device error or timeout on a chunk SHALL re-enter WAIT_READY and reissue the same chunk once; a second failure on that chunk ends the job with the error. The retry allowance resets per chunk. Link loss is never retried.
- Undefined: any failure ends the job immediately.

Verification
REQ-032 Write 600 sectors at LBA 0x1000, CHUNK_SECTORS=256, clean status (0x50) -> three ISSUEs, cmd 0x35, counts 256/256/88 at LBA 0x1000/0x1100/0x1200; done_stb; sectors_done=600; error_code=0.
REQ-033 Read 10 sectors; faux drive returns d2h_status=0x51, d2h_error=0x04 -> without RETRY_EN: error_code=1, error_status=0x0451, sectors_done=0; with RETRY_EN: the same chunk is reissued once.
REQ-034 Drive never sends D2H, TIMEOUT_CYCLES=100 -> error_code=2 exactly 100 cycles after sata_busy rises; done_stb.
REQ-035 linkup dropped in WAIT_DONE of the second chunk -> error_code=3, sectors_done=CHUNK_SECTORS.
REQ-036 req_sectors=0 -> done_stb at +1 cycle, no execute_command_stb; req_stb while busy -> ignored.
REQ-037 rst pulsed in WAIT_DONE -> all outputs at reset values the next cycle; no done_stb; a new job then runs normally.
